// File: rtl/audio_pkg.sv
// Shared types and helpers for the codec ADC receive path.
// Holds the receiver FSM state encoding, channel codes and the
// sign-extension helper used when a captured word is widened.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SHIFT = 2'd2,
    PAD   = 2'd3
  } state_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // Widest output word the sign-extension helper can produce.
  localparam int SEXT_MAX_W = 64;

  // Replicate bit (sample_w-1) of word into every bit above it.
  function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] word,
                                                 input int sample_w);
    logic [SEXT_MAX_W-1:0] r;
    logic [5:0]            msb;
    r   = word;
    msb = 6'(sample_w - 1);
    for (int i = 0; i < SEXT_MAX_W; i++) begin
      if (i >= sample_w) r[i] = word[msb];
    end
    return r;
  endfunction

endpackage

// File: rtl/audio_rx_shifter.sv
// Serial-to-parallel shifter for one audio channel slot.
// Shifts AUD_ADCDAT in MSB first and counts captured bits. 'word' is the
// completed sample including the bit on dat this cycle, so it is valid on
// the edge where last_bit is high and a shift is taken.
module audio_rx_shifter
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = 24
) (
  input  logic                AUD_BCLK,
  input  logic                rst,
  input  logic                clear,
  input  logic                shift,
  input  logic                dat,
  output logic [SAMPLE_W-1:0] word,
  output logic                last_bit
);

  localparam int CNT_W = $clog2(SAMPLE_W + 1);

  logic [SAMPLE_W-2:0] sr;
  logic [CNT_W-1:0]    bit_cnt;

  assign word     = {sr, dat};
  assign last_bit = (bit_cnt == CNT_W'(SAMPLE_W - 1));

  // Data shift register; clear together with shift loads the first bit.
  always_ff @(posedge AUD_BCLK) begin
    if (clear) begin
      sr <= shift ? {{(SAMPLE_W-2){1'b0}}, dat} : '0;
    end else if (shift) begin
      sr <= {sr[SAMPLE_W-3:0], dat};
    end
  end

  // Bit counter; counts the bits already held in sr.
  always_ff @(posedge AUD_BCLK or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (clear) begin
      bit_cnt <= shift ? CNT_W'(1) : '0;
    end else if (shift) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/audio_adc_rx.sv
// Serial audio receiver for the codec ADC path (I2S or left-justified).
// Captures both LRCK channels, commits an atomic sign-extended stereo pair
// with a one-cycle valid pulse, and flags frames cut short by an early
// LRCK edge. Optional saturating error counter: AUDIO_ADC_RX_ERRCNT_EN.
module audio_adc_rx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W  = 24,
  parameter int OUT_W     = 32,
  parameter int I2S_MODE  = 1,
  parameter int LEFT_LRCK = 0
) (
  input  logic             AUD_BCLK,
  input  logic             rst,
  input  logic             en,
  input  logic             AUD_ADCLRCK,
  input  logic             AUD_ADCDAT,
  output logic [OUT_W-1:0] left_data,
  output logic [OUT_W-1:0] right_data,
  output logic             valid,
  output logic             frame_err
`ifdef AUDIO_ADC_RX_ERRCNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam logic LEFT_LVL = 1'(LEFT_LRCK);
  localparam bit   I2S      = (I2S_MODE != 0);

  state_t             state_q, state_d;
  logic               lrck_q, lrck_armed, edge_det, new_ch, chan_q;
  logic               clear, shift, start, trunc, commit;
  logic               left_ok, last_bit;
  logic [SAMPLE_W-1:0] word;
  logic [OUT_W-1:0]   word_ext, left_pend;

  // lrck_armed masks the first cycle after reset, when lrck_q has not yet
  // seen the pin and a spurious edge could otherwise be reported.
  assign edge_det = lrck_armed && (AUD_ADCLRCK != lrck_q);
  assign new_ch   = (AUD_ADCLRCK == LEFT_LVL) ? CH_LEFT : CH_RIGHT;
  assign word_ext = OUT_W'(sext(SEXT_MAX_W'(word), SAMPLE_W));

  audio_rx_shifter #(.SAMPLE_W(SAMPLE_W)) u_shifter (
    .AUD_BCLK (AUD_BCLK),
    .rst      (rst),
    .clear    (clear),
    .shift    (shift),
    .dat      (AUD_ADCDAT),
    .word     (word),
    .last_bit (last_bit)
  );

  // LRCK history for edge detection.
  always_ff @(posedge AUD_BCLK or negedge rst) begin
    if (!rst) begin
      lrck_q     <= 1'b0;
      lrck_armed <= 1'b0;
    end else begin
      lrck_q     <= AUD_ADCLRCK;
      lrck_armed <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge AUD_BCLK or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and shifter control. DELAY marks the I2S slot whose edge
  // bit was discarded; the bit taken on leaving DELAY is the MSB. An LRCK
  // edge before the LSB was taken truncates the slot and restarts capture.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    shift   = 1'b0;
    start   = 1'b0;
    trunc   = 1'b0;
    commit  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      clear   = 1'b1;
    end else begin
      case (state_q)
        IDLE, PAD: start = edge_det;
        DELAY, SHIFT: begin
          if (edge_det) begin
            start = 1'b1;
            trunc = 1'b1;
          end else begin
            shift   = 1'b1;
            commit  = last_bit;
            state_d = last_bit ? PAD : SHIFT;
          end
        end
        default: state_d = IDLE;
      endcase
      if (start) begin
        clear = 1'b1;
        if (I2S) begin
          state_d = DELAY;
        end else begin
          shift   = 1'b1;
          state_d = SHIFT;
        end
      end
    end
  end

  // Channel of the slot currently being captured, latched at its edge.
  always_ff @(posedge AUD_BCLK or negedge rst) begin
    if (!rst)       chan_q <= CH_LEFT;
    else if (start) chan_q <= new_ch;
  end

  // Left pending slot, atomic stereo commit and pulse outputs.
  always_ff @(posedge AUD_BCLK or negedge rst) begin
    if (!rst) begin
      left_pend  <= '0;
      left_ok    <= 1'b0;
      left_data  <= '0;
      right_data <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= trunc;
      if (!en || trunc) begin
        left_ok <= 1'b0;
      end else if (commit) begin
        if (chan_q == CH_LEFT) begin
          left_pend <= word_ext;
          left_ok   <= 1'b1;
        end else if (left_ok) begin
          left_data  <= left_pend;
          right_data <= word_ext;
          valid      <= 1'b1;
          left_ok    <= 1'b0;
        end
      end
    end
  end

`ifdef AUDIO_ADC_RX_ERRCNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Saturating count of truncated frames; cleared only by reset.
  always_ff @(posedge AUD_BCLK or negedge rst) begin
    if (!rst)       err_count <= 8'd0;
    else if (trunc) err_count <= sat_inc(err_count);
  end
`endif

endmodule

// File: tb/tb_audio_adc_rx.sv
// Directed bench for audio_adc_rx: an I2S instance and a left-justified
// instance share LRCK/en/reset, each fed data in its own format.
// Error-counter checks are built when AUDIO_ADC_RX_ERRCNT_EN is defined.
module tb_audio_adc_rx;

  logic        clk = 1'b0;
  logic        rst, en, lrck, dat_i2s, dat_lj;
  logic [31:0] l_i2s, r_i2s, l_lj, r_lj;
  logic        v_i2s, fe_i2s, v_lj, fe_lj;
`ifdef AUDIO_ADC_RX_ERRCNT_EN
  logic [7:0]  ec_i2s, ec_lj;
`endif

  int cyc = 0;
  int vcnt_i2s = 0, vcnt_lj = 0, fcnt_i2s = 0, fcnt_lj = 0;
  int vcyc_i2s = 0, vcyc_lj = 0;
  logic overlap = 1'b0;
  int e0;
  int n_assert = 0, n_fail = 0;

  localparam logic [23:0] L1 = 24'h123456, R1 = 24'hABCDEF;
  localparam logic [23:0] L2 = 24'h800000, R2 = 24'h7FFFFF;

  always #5 clk = ~clk;

  audio_adc_rx #(.SAMPLE_W(24), .OUT_W(32), .I2S_MODE(1), .LEFT_LRCK(0)) u_i2s (
    .AUD_BCLK(clk), .rst(rst), .en(en), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(dat_i2s),
    .left_data(l_i2s), .right_data(r_i2s), .valid(v_i2s), .frame_err(fe_i2s)
`ifdef AUDIO_ADC_RX_ERRCNT_EN
    , .err_count(ec_i2s)
`endif
  );

  audio_adc_rx #(.SAMPLE_W(24), .OUT_W(32), .I2S_MODE(0), .LEFT_LRCK(0)) u_lj (
    .AUD_BCLK(clk), .rst(rst), .en(en), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(dat_lj),
    .left_data(l_lj), .right_data(r_lj), .valid(v_lj), .frame_err(fe_lj)
`ifdef AUDIO_ADC_RX_ERRCNT_EN
    , .err_count(ec_lj)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled 2 time units after the rising edge.
  always @(posedge clk) begin
    #2;
    if (v_i2s)  begin vcnt_i2s++; vcyc_i2s = cyc; end
    if (v_lj)   begin vcnt_lj++;  vcyc_lj  = cyc; end
    if (fe_i2s) fcnt_i2s++;
    if (fe_lj)  fcnt_lj++;
    if ((v_i2s && fe_i2s) || (v_lj && fe_lj)) overlap = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One LRCK slot of len BCLKs; en is low for 5 BCLKs from en_off if >= 0.
  task automatic slot(input logic lvl, input logic [23:0] w, input int len, input int en_off);
    for (int p = 0; p < len; p++) begin
      @(negedge clk);
      if (p == 0) e0 = cyc + 1;
      lrck    = lvl;
      en      = (en_off >= 0 && p >= en_off && p < en_off + 5) ? 1'b0 : 1'b1;
      dat_lj  = (p < 24) ? w[23-p] : 1'b0;
      dat_i2s = (p >= 1 && p <= 24) ? w[24-p] : 1'b0;
    end
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(negedge clk);
      dat_lj  = 1'b0;
      dat_i2s = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; lrck = 1'b0; dat_i2s = 1'b0; dat_lj = 1'b0;
    hold(3);
    rst = 1'b1;
    hold(3);
    chk("rst_left_i2s",  l_i2s,  32'h0);
    chk("rst_right_i2s", r_i2s,  32'h0);
    chk("rst_valid_i2s", v_i2s,  32'h0);
    chk("rst_ferr_i2s",  fe_i2s, 32'h0);
    chk("rst_left_lj",   l_lj,   32'h0);
    chk("rst_right_lj",  r_lj,   32'h0);
`ifdef AUDIO_ADC_RX_ERRCNT_EN
    chk("rst_errcnt_i2s", 32'(ec_i2s), 32'h0);
`endif
    en = 1'b1;
    hold(2);

    // First frame starts on the right channel: discarded silently.
    slot(1'b1, R1, 32, -1);
    chk("first_right_valid_i2s", vcnt_i2s, 0);
    chk("first_right_valid_lj",  vcnt_lj,  0);
    chk("first_right_ferr_i2s",  fcnt_i2s, 0);
    chk("first_right_ferr_lj",   fcnt_lj,  0);

    // Clean pair, both formats, with valid latency.
    slot(1'b0, L1, 32, -1);
    slot(1'b1, R1, 32, -1);
    hold(2);
    chk("pair1_valid_i2s", vcnt_i2s, 1);
    chk("pair1_valid_lj",  vcnt_lj,  1);
    chk("pair1_left_i2s",  l_i2s, 32'h00123456);
    chk("pair1_right_i2s", r_i2s, 32'hFFABCDEF);
    chk("pair1_left_lj",   l_lj,  32'h00123456);
    chk("pair1_right_lj",  r_lj,  32'hFFABCDEF);
    chk("lat_i2s", vcyc_i2s - e0, 24);
    chk("lat_lj",  vcyc_lj - e0,  23);
    chk("lat_diff", vcyc_i2s - vcyc_lj, 1);

    // Left cut after 10 BCLKs: error, that frame dropped, outputs hold.
    slot(1'b0, L2, 10, -1);
    slot(1'b1, R2, 32, -1);
    chk("trunc_ferr_i2s",  fcnt_i2s, 1);
    chk("trunc_ferr_lj",   fcnt_lj,  1);
    chk("trunc_valid_i2s", vcnt_i2s, 1);
    chk("trunc_valid_lj",  vcnt_lj,  1);
    chk("trunc_hold_left", l_i2s, 32'h00123456);
    slot(1'b0, L2, 32, -1);
    slot(1'b1, R2, 32, -1);
    hold(2);
    chk("pair2_valid_i2s", vcnt_i2s, 2);
    chk("pair2_valid_lj",  vcnt_lj,  2);
    chk("pair2_left_i2s",  l_i2s, 32'hFF800000);
    chk("pair2_right_i2s", r_i2s, 32'h007FFFFF);
    chk("pair2_left_lj",   l_lj,  32'hFF800000);
    chk("pair2_right_lj",  r_lj,  32'h007FFFFF);

    // 24-BCLK left slot: exact for left-justified, LSB-edge truncation for I2S.
    slot(1'b0, L1, 24, -1);
    slot(1'b1, R1, 32, -1);
    hold(2);
    chk("slot24_ferr_i2s",  fcnt_i2s, 2);
    chk("slot24_ferr_lj",   fcnt_lj,  1);
    chk("slot24_valid_i2s", vcnt_i2s, 2);
    chk("slot24_valid_lj",  vcnt_lj,  3);
    chk("slot24_left_lj",   l_lj,  32'h00123456);
    chk("slot24_left_i2s",  l_i2s, 32'hFF800000);
`ifdef AUDIO_ADC_RX_ERRCNT_EN
    chk("errcnt2_i2s", 32'(ec_i2s), 32'd2);
    chk("errcnt1_lj",  32'(ec_lj),  32'd1);
`endif

    // 25-BCLK left slot: exact fit for I2S.
    slot(1'b0, L2, 25, -1);
    slot(1'b1, R2, 32, -1);
    hold(2);
    chk("slot25_ferr_i2s",  fcnt_i2s, 2);
    chk("slot25_valid_i2s", vcnt_i2s, 3);
    chk("slot25_valid_lj",  vcnt_lj,  4);
    chk("slot25_right_i2s", r_i2s, 32'h007FFFFF);

    // en low for 5 BCLKs mid-left: partial flushed, next right dropped.
    slot(1'b0, L1, 32, 12);
    chk("en_hold_left_i2s", l_i2s, 32'hFF800000);
    slot(1'b1, R1, 32, -1);
    hold(2);
    chk("en_valid_i2s", vcnt_i2s, 3);
    chk("en_valid_lj",  vcnt_lj,  4);
    chk("en_ferr_i2s",  fcnt_i2s, 2);
    chk("en_hold_right_lj", r_lj, 32'h007FFFFF);
    slot(1'b0, L1, 32, -1);
    slot(1'b1, R1, 32, -1);
    hold(2);
    chk("en_pair_valid_i2s", vcnt_i2s, 4);
    chk("en_pair_valid_lj",  vcnt_lj,  5);
    chk("en_pair_left_i2s",  l_i2s, 32'h00123456);
    chk("en_pair_right_lj",  r_lj,  32'hFFABCDEF);

    // 301 four-BCLK slots: 300 truncations.
    for (int i = 0; i < 301; i++) slot(i[0], L1, 4, -1);
    hold(2);
    chk("many_ferr_i2s",  fcnt_i2s, 302);
    chk("many_ferr_lj",   fcnt_lj,  301);
    chk("many_valid_i2s", vcnt_i2s, 4);
`ifdef AUDIO_ADC_RX_ERRCNT_EN
    chk("errcnt_sat_i2s", 32'(ec_i2s), 32'hFF);
    chk("errcnt_sat_lj",  32'(ec_lj),  32'hFF);
`endif
    chk("valid_ferr_overlap", 32'(overlap), 32'h0);

    // Reset returns everything to zero.
    @(negedge clk);
    rst = 1'b0;
    hold(2);
    chk("rst2_left_i2s",  l_i2s, 32'h0);
    chk("rst2_right_lj",  r_lj,  32'h0);
`ifdef AUDIO_ADC_RX_ERRCNT_EN
    chk("rst2_errcnt_i2s", 32'(ec_i2s), 32'h0);
    chk("rst2_errcnt_lj",  32'(ec_lj),  32'h0);
`endif
    rst = 1'b1;
    hold(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
